program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 122 ++++++++++++
 tb/tb_program_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader that writes 28-bit instruction words into memory
module program_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_WORDS = 256
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iStart,
  input  logic [7:0]  iByte,
  input  logic        iByteValid,
  output logic        oByteReady,
  output logic        oWriteEnable,
  output logic [15:0] oWriteAddress,
  output logic [27:0] oInstruction,
  output logic        oCpuReset,
  output logic        oDone,
  output logic        oError
);

  typedef enum logic [2:0] {
    IDLE, SYNC, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR
  } state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state, next_state;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [27:8] asm_word;
  logic [7:0]  checksum;
  logic        ready;
  logic        xfer;
  logic [15:0] len_next;
  logic        last_word;

  assign xfer      = ready & iByteValid;
  assign len_next  = {len[15:8], iByte};
  assign last_word = (16'(word_idx + 16'd1) == len);

  always_ff @(posedge Clock) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    case (state)
      SYNC, LEN_HI, LEN_LO, DATA, CHECK: ready = 1'b1;
      default: ready = 1'b0;
    endcase
    if (iStart) begin
      next_state = SYNC;
    end else if (xfer) begin
      case (state)
        SYNC:   if (iByte == SYNC_BYTE) next_state = LEN_HI;
        LEN_HI: next_state = LEN_LO;
        LEN_LO: begin
          if (len_next == 16'd0 || {1'b0, len_next} > MAX_W) next_state = ERROR;
          else                                               next_state = DATA;
        end
        DATA:   if (byte_cnt == 2'd3 && last_word) next_state = CHECK;
        CHECK:  next_state = (iByte == checksum) ? DONE : ERROR;
        default: next_state = state;
      endcase
    end
  end

  assign oByteReady = ready;

  // Status flags are registered from next_state so they line up with the state register.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      len           <= 16'd0;
      word_idx      <= 16'd0;
      byte_cnt      <= 2'd0;
      asm_word      <= '0;
      checksum      <= 8'd0;
      oWriteEnable  <= 1'b0;
      oWriteAddress <= 16'd0;
      oInstruction  <= 28'd0;
      oDone         <= 1'b0;
      oError        <= 1'b0;
      oCpuReset     <= 1'b1;
    end else begin
      oWriteEnable <= 1'b0;
      oDone        <= (next_state == DONE);
      oError       <= (next_state == ERROR);
      oCpuReset    <= (next_state != DONE);
      if (iStart) begin
        len      <= 16'd0;
        word_idx <= 16'd0;
        byte_cnt <= 2'd0;
        asm_word <= '0;
        checksum <= 8'd0;
      end else if (xfer) begin
        case (state)
          LEN_HI: len[15:8] <= iByte;
          LEN_LO: len[7:0]  <= iByte;
          DATA: begin
            checksum <= checksum ^ iByte;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_word[27:24] <= iByte[3:0];
              2'd1: asm_word[23:16] <= iByte;
              2'd2: asm_word[15:8]  <= iByte;
              default: begin
                oWriteEnable  <= 1'b1;
                oInstruction  <= {asm_word, iByte};
                oWriteAddress <= word_idx;
                word_idx      <= word_idx + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - table-driven self-checking bench for program_loader
module tb_program_loader;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iStart = 1'b0;
  logic [7:0]  iByte = 8'd0;
  logic        iByteValid = 1'b0;
  logic        oByteReady;
  logic        oWriteEnable;
  logic [15:0] oWriteAddress;
  logic [27:0] oInstruction;
  logic        oCpuReset;
  logic        oDone;
  logic        oError;

  program_loader #(.SYNC_BYTE(8'hA5), .MAX_WORDS(256)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iByte(iByte),
    .iByteValid(iByteValid), .oByteReady(oByteReady), .oWriteEnable(oWriteEnable),
    .oWriteAddress(oWriteAddress), .oInstruction(oInstruction), .oCpuReset(oCpuReset),
    .oDone(oDone), .oError(oError)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [127:0] s;      // stream bytes, first byte in the top byte
    int           n;
    int           nw;
    logic [15:0]  a0, a1;
    logic [27:0]  d0, d1;
    logic         done;
    logic         err;
    bit           gaps;
  } vec_t;

  vec_t        v [7];
  logic [15:0] wr_addr [$];
  logic [27:0] wr_data [$];
  int          checks = 0;
  int          errors = 0;

  always begin
    @(posedge Clock);
    #1;
    if (oWriteEnable) begin
      wr_addr.push_back(oWriteAddress);
      wr_data.push_back(oInstruction);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok = 1'b0;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        iByteValid = 1'b0;
        tick(1);
      end
    end
    iByte      = b;
    iByteValid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (oByteReady) ok = 1'b1;
      tick(1);
    end
    iByteValid = 1'b0;
    if (!ok) check("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_stream(input logic [127:0] s, input int n, input bit gaps);
    for (int i = 0; i < n; i++) send_byte(s[127 - 8*i -: 8], gaps);
  endtask

  initial begin
    v[0] = '{{96'hA500020123456_70ABCDEF098, 32'h0}, 12, 2, 16'd0, 16'd1,
             28'h1234567, 28'hABCDEF0, 1'b1, 1'b0, 1'b0};
    v[1] = '{{96'hA500020123456_70ABCDEF099, 32'h0}, 12, 2, 16'd0, 16'd1,
             28'h1234567, 28'hABCDEF0, 1'b0, 1'b1, 1'b0};
    v[2] = '{{24'hA50000, 104'h0}, 3, 0, 16'd0, 16'd0, 28'h0, 28'h0, 1'b0, 1'b1, 1'b0};
    v[3] = '{{24'hA50101, 104'h0}, 3, 0, 16'd0, 16'd0, 28'h0, 28'h0, 1'b0, 1'b1, 1'b0};
    v[4] = '{{88'h00FF5AA500010F0000010E, 40'h0}, 11, 1, 16'd0, 16'd0,
             28'hF000001, 28'h0, 1'b1, 1'b0, 1'b0};
    v[5] = '{{96'hA500020123456_70ABCDEF098, 32'h0}, 12, 2, 16'd0, 16'd1,
             28'h1234567, 28'hABCDEF0, 1'b1, 1'b0, 1'b1};
    v[6] = '{{64'hA50001F1223344A4, 64'h0}, 8, 1, 16'd0, 16'd0,
             28'h1223344, 28'h0, 1'b1, 1'b0, 1'b0};

    Reset = 1'b0;
    tick(2);
    check("rst_ready", 32'(oByteReady), 32'd0);
    check("rst_we", 32'(oWriteEnable), 32'd0);
    check("rst_addr", 32'(oWriteAddress), 32'd0);
    check("rst_instr", 32'(oInstruction), 32'd0);
    check("rst_done", 32'(oDone), 32'd0);
    check("rst_error", 32'(oError), 32'd0);
    check("rst_cpu_reset", 32'(oCpuReset), 32'd1);
    Reset = 1'b1;
    tick(1);

    for (int k = 0; k < 7; k++) begin
      wr_addr.delete();
      wr_data.delete();
      pulse_start();
      check($sformatf("v%0d_start_ready", k), 32'(oByteReady), 32'd1);
      send_stream(v[k].s, v[k].n, v[k].gaps);
      tick(3);
      check($sformatf("v%0d_done", k), 32'(oDone), 32'(v[k].done));
      check($sformatf("v%0d_error", k), 32'(oError), 32'(v[k].err));
      check($sformatf("v%0d_cpu_reset", k), 32'(oCpuReset), 32'(!v[k].done));
      check($sformatf("v%0d_ready", k), 32'(oByteReady), 32'd0);
      check($sformatf("v%0d_nwrites", k), 32'(wr_addr.size()), 32'(v[k].nw));
      if (v[k].nw > 0 && wr_addr.size() > 0) begin
        check($sformatf("v%0d_addr0", k), 32'(wr_addr[0]), 32'(v[k].a0));
        check($sformatf("v%0d_data0", k), 32'(wr_data[0]), 32'(v[k].d0));
      end
      if (v[k].nw > 1 && wr_addr.size() > 1) begin
        check($sformatf("v%0d_addr1", k), 32'(wr_addr[1]), 32'(v[k].a1));
        check($sformatf("v%0d_data1", k), 32'(wr_data[1]), 32'(v[k].d1));
      end
    end

    // Length of exactly MAX_WORDS is accepted.
    pulse_start();
    send_stream({24'hA50100, 104'h0}, 3, 1'b0);
    tick(1);
    check("len256_ready", 32'(oByteReady), 32'd1);
    check("len256_error", 32'(oError), 32'd0);

    // Reset after byte2 of word 1: partial word dropped, no more strobes.
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    send_stream({80'hA5000201234567_0ABCDE, 48'h0}, 10, 1'b0);
    Reset = 1'b0;
    tick(1);
    Reset = 1'b1;
    check("midrst_we", 32'(oWriteEnable), 32'd0);
    check("midrst_ready", 32'(oByteReady), 32'd0);
    check("midrst_cpu_reset", 32'(oCpuReset), 32'd1);
    iByte = 8'hF0;
    iByteValid = 1'b1;
    tick(5);
    iByteValid = 1'b0;
    check("midrst_nwrites", 32'(wr_addr.size()), 32'd1);
    check("midrst_idle_ready", 32'(oByteReady), 32'd0);

    // Reset wins over a simultaneous iStart.
    Reset  = 1'b0;
    iStart = 1'b1;
    tick(1);
    Reset  = 1'b1;
    iStart = 1'b0;
    check("rst_prio_ready", 32'(oByteReady), 32'd0);

    // iStart mid-DATA restarts; the next load writes from address 0.
    pulse_start();
    send_stream({64'hA50002012345670A, 64'h0}, 8, 1'b0);
    tick(1);
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    check("restart_error", 32'(oError), 32'd0);
    send_stream(v[0].s, v[0].n, 1'b0);
    tick(3);
    check("restart_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() > 1) begin
      check("restart_addr0", 32'(wr_addr[0]), 32'd0);
      check("restart_addr1", 32'(wr_addr[1]), 32'd1);
      check("restart_data1", 32'(wr_data[1]), 32'h0ABCDEF0);
    end
    check("restart_done", 32'(oDone), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
